// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and defaults for the binary_to_gray encoder.
// Functions work on a wide word; callers zero-extend and truncate to their width.
package gray_pkg;

  localparam int GRAY_DEFAULT_WIDTH = 4;
  localparam int GRAY_MAX_WIDTH     = 64;

  typedef logic [GRAY_MAX_WIDTH-1:0] gray_word_t;

  function automatic gray_word_t bin2gray(gray_word_t bin);
    return bin ^ (bin >> 1);
  endfunction

  // Prefix XOR from the MSB down; zero-extended upper bits decode to zero.
  function automatic gray_word_t gray2bin(gray_word_t gray);
    gray_word_t bin;
    bin[GRAY_MAX_WIDTH-1] = gray[GRAY_MAX_WIDTH-1];
    for (int i = GRAY_MAX_WIDTH-2; i >= 0; i--)
      bin[i] = bin[i+1] ^ gray[i];
    return bin;
  endfunction

  function automatic logic popcount_is_one(gray_word_t x);
    return (x != '0) && ((x & (x - gray_word_t'(1))) == '0);
  endfunction

endpackage

// File: rtl/gray_to_binary.sv
// Combinational Gray-to-binary decoder, used by the optional round-trip self-check.
module gray_to_binary
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  gray_word_t dec;

  always_comb begin
    dec   = gray2bin(gray_word_t'(gray_i));
    bin_o = dec[WIDTH-1:0];
  end

endmodule

// File: rtl/binary_to_gray.sv
// Registered binary-to-Gray encoder with a unit-step flag on consecutive codes.
// Define BIN2GRAY_ROUNDTRIP_CHECK_EN to add a decoder-based roundtrip_err self-check.
module binary_to_gray
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] binary_in,
  output logic [WIDTH-1:0] gray_out,
  output logic             valid_out,
  output logic             unit_step
`ifdef BIN2GRAY_ROUNDTRIP_CHECK_EN
  ,
  output logic             roundtrip_err
`endif
);

  logic [WIDTH-1:0] gray_q, gray_d;
  logic             valid_q;
  logic             step_q, step_d;
  gray_word_t       enc;

  // gray_q doubles as the previous code that the next capture is compared against.
  always_comb begin
    enc    = bin2gray(gray_word_t'(binary_in));
    gray_d = enc[WIDTH-1:0];
    step_d = valid_q && popcount_is_one(gray_word_t'(gray_d ^ gray_q));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gray_q  <= '0;
      valid_q <= 1'b0;
      step_q  <= 1'b0;
    end else if (en) begin
      gray_q  <= gray_d;
      valid_q <= 1'b1;
      step_q  <= step_d;
    end
  end

  assign gray_out  = gray_q;
  assign valid_out = valid_q;
  assign unit_step = step_q;

`ifdef BIN2GRAY_ROUNDTRIP_CHECK_EN
  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] dec_bin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  bin_q <= '0;
    else if (en) bin_q <= binary_in;
  end

  gray_to_binary #(.WIDTH(WIDTH)) u_dec (
    .gray_i (gray_q),
    .bin_o  (dec_bin)
  );

  assign roundtrip_err = valid_q && (dec_bin != bin_q);
`endif

endmodule

// File: tb/tb_binary_to_gray.sv
// Directed bench for binary_to_gray at WIDTH=4 with hand-computed Gray codes.
module tb_binary_to_gray;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic [W-1:0] binary_in;
  logic [W-1:0] gray_out;
  logic         valid_out;
  logic         unit_step;
`ifdef BIN2GRAY_ROUNDTRIP_CHECK_EN
  logic         roundtrip_err;
`endif

  int errs   = 0;
  int checks = 0;

  localparam logic [3:0] GTAB [16] = '{
    4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
    4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000
  };

  binary_to_gray #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .binary_in (binary_in),
    .gray_out  (gray_out),
    .valid_out (valid_out),
    .unit_step (unit_step)
`ifdef BIN2GRAY_ROUNDTRIP_CHECK_EN
    ,
    .roundtrip_err (roundtrip_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic outs(input string tag, input logic [3:0] g, input logic v, input logic s);
    chk({tag, ".gray"},  32'(gray_out),  32'(g));
    chk({tag, ".valid"}, 32'(valid_out), 32'(v));
    chk({tag, ".step"},  32'(unit_step), 32'(s));
  endtask

  // Drive on the falling edge, sample 1 ns after the next rising edge.
  task automatic cyc(input logic e, input logic [W-1:0] b);
    @(negedge clk);
    en        = e;
    binary_in = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    en        = 1'b0;
    binary_in = '0;
    #3;
    outs("reset", 4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, 4'b1010);
    outs("idle_after_reset", 4'b0000, 1'b0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, W'(i));
      outs($sformatf("sweep%0d", i), GTAB[i], 1'b1, (i > 0));
    end

    cyc(1'b1, 4'b0000);
    outs("wrap", 4'b0000, 1'b1, 1'b1);
    cyc(1'b1, 4'b0101);
    outs("jump", 4'b0111, 1'b1, 1'b0);
    cyc(1'b1, 4'b0101);
    outs("repeat", 4'b0111, 1'b1, 1'b0);
    cyc(1'b1, 4'b0100);
    outs("step_in", 4'b0110, 1'b1, 1'b1);

    cyc(1'b0, 4'b1111);
    outs("hold0", 4'b0110, 1'b1, 1'b1);
    cyc(1'b0, 4'b0011);
    outs("hold1", 4'b0110, 1'b1, 1'b1);
    cyc(1'b0, 4'bxxxx);
    outs("hold_x", 4'b0110, 1'b1, 1'b1);

    // Async reset asserted mid-cycle, no clock edge in between.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    outs("async_reset", 4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    cyc(1'b1, 4'b0001);
    outs("first_after_rst", 4'b0001, 1'b1, 1'b0);
    cyc(1'b1, 4'b0011);
    outs("two_bit", 4'b0010, 1'b1, 1'b0);
    cyc(1'b1, 4'b1111);
    outs("msb_jump", 4'b1000, 1'b1, 1'b0);
    cyc(1'b1, 4'b0000);
    outs("wrap2", 4'b0000, 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
